// File: rtl/a2d_spi_slave_model_if.sv
// SPI command-side signals driven by the master into the A2D model.
// MISO is a tri-state port on the model itself, so it is not part of this bundle.
interface a2d_spi_slave_model_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;

   modport master (output SS_n, output SCLK, output MOSI);
   modport slave  (input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/a2d_spi_slave_model.sv
// ADC128S-style 8-channel 12-bit SPI A2D slave model. Each 16-bit frame latches a
// channel address and returns the value of the channel addressed in the previous frame.
module a2d_spi_slave_model #(
   parameter logic [2:0] LD_LFT_CH  = 3'd0,
   parameter logic [2:0] LD_RGHT_CH = 3'd4,
   parameter logic [2:0] STEER_CH   = 3'd5,
   parameter logic [2:0] BATT_CH    = 3'd6
) (
   input  logic                   clk,
   input  logic                   rst,
   a2d_spi_slave_model_if.slave   spi,
   output wire                    MISO,
   input  logic [11:0]            ld_cell_lft,
   input  logic [11:0]            ld_cell_rght,
   input  logic [11:0]            steerPot,
   input  logic [11:0]            batt
);

   logic ss_n_s1, ss_n_s2, ss_n_s3;
   logic sclk_s1, sclk_s2, sclk_s3;

   logic [15:0] rx_q, rx_d;
   logic [15:0] tx_q, tx_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  cur_ch_q, cur_ch_d;
   logic        first_fall_q, first_fall_d;

   logic        sclk_rise, sclk_fall, ss_fall, ss_rise, active, frame_done;
   logic [11:0] ch_data;

   // Synchronizers preset idle-high so reset release never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_n_s1 <= 1'b1;
         ss_n_s2 <= 1'b1;
         ss_n_s3 <= 1'b1;
         sclk_s1 <= 1'b1;
         sclk_s2 <= 1'b1;
         sclk_s3 <= 1'b1;
      end else begin
         ss_n_s1 <= spi.SS_n;
         ss_n_s2 <= ss_n_s1;
         ss_n_s3 <= ss_n_s2;
         sclk_s1 <= spi.SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 & sclk_s3;
   assign ss_fall   = ~ss_n_s2 & ss_n_s3;
   assign ss_rise   = ss_n_s2 & ~ss_n_s3;
   assign active    = ~ss_n_s2;

   // Channel mux looks at the next cur_ch so a back-to-back frame sees the new address.
   always_comb begin
      ch_data = 12'h000;
      if (cur_ch_d == LD_LFT_CH)       ch_data = ld_cell_lft;
      else if (cur_ch_d == LD_RGHT_CH) ch_data = ld_cell_rght;
      else if (cur_ch_d == STEER_CH)   ch_data = steerPot;
      else if (cur_ch_d == BATT_CH)    ch_data = batt;
   end

   always_comb begin
      rx_d         = rx_q;
      tx_d         = tx_q;
      bit_cnt_d    = bit_cnt_q;
      first_fall_d = first_fall_q;
      frame_done   = ss_rise && (bit_cnt_q == 5'd16);
      cur_ch_d     = frame_done ? rx_q[13:11] : cur_ch_q;

      if (ss_fall) begin
         tx_d         = {4'b0000, ch_data};
         bit_cnt_d    = 5'd0;
         first_fall_d = 1'b1;
      end else if (active) begin
         if (sclk_rise) begin
            rx_d = {rx_q[14:0], spi.MOSI};
            if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
         end
         // The first fall only opens the frame; the MSB must stay put for the first rise.
         if (sclk_fall) begin
            if (first_fall_q) first_fall_d = 1'b0;
            else              tx_d = {tx_q[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q         <= 16'h0000;
         tx_q         <= 16'h0000;
         bit_cnt_q    <= 5'd0;
         cur_ch_q     <= 3'd0;
         first_fall_q <= 1'b0;
      end else begin
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         bit_cnt_q    <= bit_cnt_d;
         cur_ch_q     <= cur_ch_d;
         first_fall_q <= first_fall_d;
      end
   end

   assign MISO = (!rst && !ss_n_s2) ? tx_q[15] : 1'bz;

endmodule

// File: tb/tb_a2d_spi_slave_model.sv
// Bench for the A2D SPI slave model: directed test-plan frames plus random frames,
// checked by a frame monitor against a queue of expected reply words.
module tb_a2d_spi_slave_model;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   a2d_spi_slave_model_if spi ();
   wire miso;
   pullup (miso);

   logic [11:0] ld_cell_lft, ld_cell_rght, steer_pot, batt;

   a2d_spi_slave_model dut (
      .clk          (clk),
      .rst          (rst),
      .spi          (spi),
      .MISO         (miso),
      .ld_cell_lft  (ld_cell_lft),
      .ld_cell_rght (ld_cell_rght),
      .steerPot     (steer_pot),
      .batt         (batt)
   );

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [15:0] exp_q[$];
   logic [2:0]  model_ch;

   // Reference: reply word is the addressed channel's current analog value, zero-extended.
   function automatic logic [15:0] model_word(input logic [2:0] ch);
      case (ch)
         3'd0:    return {4'h0, ld_cell_lft};
         3'd4:    return {4'h0, ld_cell_rght};
         3'd5:    return {4'h0, steer_pot};
         3'd6:    return {4'h0, batt};
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] addr_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_hiz(input string name);
      n_vec++;
      if (miso === 1'b0) begin
         n_miss++;
         $display("FAIL %s: MISO got %b, required high-impedance", name, miso);
      end
   endtask

   // chg_bit < 0 means no mid-frame input change; chg_sel picks lft/rght/steer/batt.
   task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                        input int chg_sel, input logic [11:0] chg_val);
      if (nbits == 16) exp_q.push_back(model_word(model_ch));
      spi.SS_n = 1'b0;
      clks(4);
      for (int i = 0; i < nbits; i++) begin
         spi.SCLK = 1'b0;
         spi.MOSI = cmd[15-i];
         clks(5);
         spi.SCLK = 1'b1;
         clks(5);
         if (i == chg_bit) begin
            case (chg_sel)
               0:       ld_cell_lft  = chg_val;
               1:       ld_cell_rght = chg_val;
               2:       steer_pot    = chg_val;
               default: batt         = chg_val;
            endcase
         end
      end
      spi.SS_n = 1'b1;
      clks(6);
      if (nbits == 16) model_ch = cmd[13:11];
   endtask

   task automatic full(input logic [2:0] ch);
      frame(addr_cmd(ch), 16, -1, 0, 12'h000);
   endtask

   // Monitor: captures MISO on each SCLK rise inside a frame; full frames are scored.
   initial begin : monitor
      logic [15:0] word;
      logic [15:0] exp_w;
      int          nb;
      forever begin
         @(negedge spi.SS_n);
         word = 16'h0000;
         nb   = 0;
         forever begin
            @(posedge spi.SCLK or posedge spi.SS_n);
            if (spi.SS_n) break;
            word = {word[14:0], miso};
            nb++;
         end
         if (nb == 16) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL frame_unexpected: got %h, required no frame", word);
            end else begin
               exp_w = exp_q.pop_front();
               if (word !== exp_w) begin
                  n_miss++;
                  $display("FAIL frame_word: got %h, required %h", word, exp_w);
               end
            end
         end
      end
   end

   initial begin : stim
      rst          = 1'b1;
      spi.SS_n     = 1'b1;
      spi.SCLK     = 1'b1;
      spi.MOSI     = 1'b0;
      ld_cell_lft  = 12'h000;
      ld_cell_rght = 12'h000;
      steer_pot    = 12'h000;
      batt         = 12'h000;
      model_ch     = 3'd0;
      clks(4);
      check_hiz("reset_miso");
      rst = 1'b0;
      clks(4);
      check_hiz("idle_miso");

      // First frame after reset returns channel 0, then the addressed channel 4.
      ld_cell_lft  = 12'h200;
      ld_cell_rght = 12'h3A5;
      frame(16'h2000, 16, -1, 0, 12'h000);
      full(3'd1);

      steer_pot    = 12'h800;
      batt         = 12'hFFF;
      ld_cell_lft  = 12'h123;
      ld_cell_rght = 12'h456;
      full(3'd5);
      full(3'd6);
      full(3'd0);
      full(3'd4);
      full(3'd3);

      // Unmapped address reads as zero.
      full(3'd0);
      full(3'd4);

      // Aborted frame to channel 6 must leave the channel-4 address in place.
      frame(addr_cmd(3'd6), 8, -1, 0, 12'h000);
      full(3'd6);

      // Mid-frame change of batt must not disturb the word in flight.
      batt = 12'hC00;
      frame(addr_cmd(3'd6), 16, -1, 0, 12'h000);
      frame(addr_cmd(3'd6), 16, 5, 3, 12'h100);
      full(3'd0);

      // Reset in the middle of a frame after cur_ch was set to 6.
      full(3'd6);
      spi.SS_n = 1'b0;
      clks(4);
      for (int i = 0; i < 4; i++) begin
         spi.SCLK = 1'b0;
         spi.MOSI = 1'b1;
         clks(5);
         spi.SCLK = 1'b1;
         clks(5);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clks(1);
         check_hiz("midframe_reset_miso");
      end
      spi.SS_n = 1'b1;
      clks(3);
      rst      = 1'b0;
      model_ch = 3'd0;
      clks(4);
      ld_cell_lft = 12'hABC;
      full(3'd5);

      for (int n = 0; n < 50; n++) begin
         int nbits;
         int chg;
         ld_cell_lft  = 12'($urandom);
         ld_cell_rght = 12'($urandom);
         steer_pot    = 12'($urandom);
         batt         = 12'($urandom);
         nbits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
         chg   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1;
         frame(16'($urandom), nbits, chg, int'($urandom_range(0, 3)), 12'($urandom));
      end

      clks(20);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL frames_missing: got %0d unscored, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
